// File: rtl/dsp_mac_sequencer.sv
// Initiator for one DSP MAC instance: streams (coef, oper) taps into the DSP, waits out its
// pipeline and returns the accumulated MAC_OUT as a single result beat.
module dsp_mac_sequencer #(
  parameter int         TAPS_W  = 8,
  parameter int         DSP_LAT = 2,
  parameter logic [1:0] MODE    = 2'b00,
  parameter logic [1:0] OUTSEL  = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_coef,
  input  logic [31:0]       s_oper,
  input  logic              s_last,
  input  logic              rnd_cfg,
  input  logic              sat_cfg,
  output logic [31:0]       dsp_coef,
  output logic [31:0]       dsp_oper,
  output logic              dsp_enable,
  output logic              dsp_clr,
  output logic              dsp_rnd,
  output logic              dsp_sat,
  output logic [1:0]        dsp_mode_sel,
  output logic [1:0]        dsp_out_sel,
  input  logic [63:0]       dsp_mac_out,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [63:0]       r_data,
  output logic [TAPS_W-1:0] r_taps,
  output logic              r_ovf
);

  localparam int CW = $clog2(DSP_LAT + 2);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t            state, nxt;
  logic [CW-1:0]     drain_cnt;
  logic [TAPS_W-1:0] tap_cnt;
  logic              ovf;
  logic              accept;

  assign dsp_mode_sel = MODE;
  assign dsp_out_sel  = OUTSEL;
  assign s_ready      = !rst && (state == IDLE || state == ACCUM);
  assign accept       = s_valid && s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, ACCUM: if (accept) nxt = s_last ? DRAIN : ACCUM;
      DRAIN:       if (drain_cnt == '0) nxt = HOLD;
      HOLD:        if (r_ready) nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_coef   <= '0;
      dsp_oper   <= '0;
      dsp_enable <= 1'b0;
      dsp_clr    <= 1'b0;
      dsp_rnd    <= 1'b0;
      dsp_sat    <= 1'b0;
      drain_cnt  <= '0;
      tap_cnt    <= '0;
      ovf        <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_taps     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      dsp_enable <= accept;
      dsp_clr    <= accept && state == IDLE;
      if (accept) begin
        dsp_coef <= s_coef;
        dsp_oper <= s_oper;
      end
      if (accept && state == IDLE) begin
        dsp_rnd <= rnd_cfg;
        dsp_sat <= sat_cfg;
        tap_cnt <= TAPS_W'(1);
        ovf     <= 1'b0;
      end else if (accept) begin
        // Count pins at all-ones; further taps still reach the DSP but flag overflow.
        if (&tap_cnt) ovf <= 1'b1;
        else          tap_cnt <= tap_cnt + 1'b1;
      end
      // Loaded on the last accept: one cycle for the ENABLE register, DSP_LAT for the DSP.
      if (accept && s_last)
        drain_cnt <= CW'(DSP_LAT + 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 1'b1;
      if (state == DRAIN && drain_cnt == '0) begin
        r_data  <= dsp_mac_out;
        r_taps  <= tap_cnt;
        r_ovf   <= ovf;
        r_valid <= 1'b1;
      end
      if (state == HOLD && r_ready) begin
        r_valid <= 1'b0;
        dsp_rnd <= 1'b0;
        dsp_sat <= 1'b0;
      end
    end
  end

endmodule
